// File: rtl/mjpg_ereq_scheduler.sv
// rtl/mjpg_ereq_scheduler.sv - per-MCU Y/Cb/Cr entropy request sequencer for one 8-line band
// Optional build macro MJPG_SCHED_STATS_EN adds the band_cycles statistics output.
module mjpg_ereq_scheduler #(
  parameter int SLOT_Y = 5,
  parameter int SLOT_C = 3,
  parameter int GUARD  = 8,
  parameter int MCU_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             line_go,
  input  logic [MCU_W-1:0] h_mcu,
  input  logic             hdr_busy,
  input  logic [5:0]       elen_y,
  input  logic [5:0]       elen_cb,
  input  logic [5:0]       elen_cr,
  output logic [2:0]       ereq,
  output logic [MCU_W-1:0] e_x_mcu_y,
  output logic [MCU_W-1:0] e_x_mcu_cb,
  output logic [MCU_W-1:0] e_x_mcu_cr,
  output logic             busy,
  output logic             band_done,
  output logic             err_overrun,
  output logic             err_collision
`ifdef MJPG_SCHED_STATS_EN
  ,
  output logic [15:0]      band_cycles
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_PEND, S_REQ_Y, S_REQ_CB, S_REQ_CR, S_GUARD} state_t;
  localparam int SW = 8;

  state_t           state, state_d;
  logic [SW-1:0]    slot_cnt;
  logic [MCU_W-1:0] h_lat, h_lat_d;
  logic [MCU_W-1:0] x_y_d, x_cb_d, x_cr_d;
  logic [2:0]       ereq_d;
  logic             busy_d, done_d, ovr_d, col_d;
  logic             accept, multi;

  assign accept = (state == S_IDLE) && line_go && !frame_start;
  assign multi  = ((elen_y != 6'd0) && (elen_cb != 6'd0)) ||
                  ((elen_y != 6'd0) && (elen_cr != 6'd0)) ||
                  ((elen_cb != 6'd0) && (elen_cr != 6'd0));

  // slot_cnt counts cycles spent in the current state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      slot_cnt <= '0;
    end else begin
      state    <= state_d;
      slot_cnt <= (state_d != state) ? '0 : slot_cnt + SW'(1);
    end
  end

  always_comb begin
    state_d = state;
    if (frame_start) begin
      state_d = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (line_go && h_mcu != '0) state_d = hdr_busy ? S_PEND : S_REQ_Y;
        S_PEND:   if (!hdr_busy) state_d = S_REQ_Y;
        S_REQ_Y:  if (slot_cnt == SW'(SLOT_Y - 1)) state_d = S_REQ_CB;
        S_REQ_CB: if (slot_cnt == SW'(SLOT_C - 1)) state_d = S_REQ_CR;
        S_REQ_CR: if (slot_cnt == SW'(SLOT_C - 1)) state_d = S_GUARD;
        // e_x_mcu_cr already counts the MCU just finished, so it equals count + 1
        S_GUARD:  if (slot_cnt == SW'(GUARD - 1)) state_d = (e_x_mcu_cr < h_lat) ? S_REQ_Y : S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    ereq_d  = 3'b000;
    busy_d  = (state_d != S_IDLE);
    done_d  = !frame_start && ((state != S_IDLE && state_d == S_IDLE) ||
                               (accept && h_mcu == '0));
    ovr_d   = frame_start ? 1'b0 : (err_overrun || (line_go && state != S_IDLE));
    col_d   = frame_start ? 1'b0 : (err_collision || multi);
    h_lat_d = accept ? h_mcu : h_lat;
    x_y_d   = e_x_mcu_y;
    x_cb_d  = e_x_mcu_cb;
    x_cr_d  = e_x_mcu_cr;
    case (state_d)
      S_REQ_Y:  ereq_d = 3'b001;
      S_REQ_CB: ereq_d = 3'b010;
      S_REQ_CR: ereq_d = 3'b100;
      default:  ereq_d = 3'b000;
    endcase
    if (frame_start || accept) begin
      x_y_d  = '0;
      x_cb_d = '0;
      x_cr_d = '0;
    end else begin
      if (state == S_REQ_Y  && state_d != S_REQ_Y)  x_y_d  = e_x_mcu_y  + MCU_W'(1);
      if (state == S_REQ_CB && state_d != S_REQ_CB) x_cb_d = e_x_mcu_cb + MCU_W'(1);
      if (state == S_REQ_CR && state_d != S_REQ_CR) x_cr_d = e_x_mcu_cr + MCU_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ereq          <= 3'b000;
      busy          <= 1'b0;
      band_done     <= 1'b0;
      err_overrun   <= 1'b0;
      err_collision <= 1'b0;
      h_lat         <= '0;
      e_x_mcu_y     <= '0;
      e_x_mcu_cb    <= '0;
      e_x_mcu_cr    <= '0;
    end else begin
      ereq          <= ereq_d;
      busy          <= busy_d;
      band_done     <= done_d;
      err_overrun   <= ovr_d;
      err_collision <= col_d;
      h_lat         <= h_lat_d;
      e_x_mcu_y     <= x_y_d;
      e_x_mcu_cb    <= x_cb_d;
      e_x_mcu_cr    <= x_cr_d;
    end
  end

`ifdef MJPG_SCHED_STATS_EN
  // run_cnt pre-counts the accept cycle and the band_done cycle
  logic [15:0] run_cnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_cnt     <= '0;
      band_cycles <= '0;
    end else if (frame_start) begin
      run_cnt     <= '0;
      band_cycles <= '0;
    end else if (accept) begin
      run_cnt <= 16'd2;
      if (h_mcu == '0) band_cycles <= 16'd2;
    end else if (state != S_IDLE) begin
      run_cnt <= (run_cnt == 16'hFFFF) ? run_cnt : run_cnt + 16'd1;
      if (state_d == S_IDLE) band_cycles <= (run_cnt == 16'hFFFF) ? run_cnt : run_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/mjpg_ereq_scheduler.md
Name: mjpg_ereq_scheduler

Overview:
Sequences entropy-coded output requests to the three component encoders (Y, Cb, Cr) for one 8-line MCU band, one MCU at a time, in fixed per-component slots.
Sits between the band-ready detection in the MJPEG encoder top and the component encoders' ereq/e_x_mcu inputs.
Guarantees that only one component drives the bitstream packer at a time, and flags overruns and collisions.

Parameters:
SLOT_Y, 5, cycles ereq[0] is held per MCU (Y encoder DCT threshold + 1)
SLOT_C, 3, cycles ereq[1] and ereq[2] are each held per MCU
GUARD, 8, idle cycles after each MCU's Cr slot with no ereq asserted
MCU_W, 8, width of MCU column counters

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
frame_start  in  1  one-cycle pulse at frame start; aborts any band and clears errors
line_go  in  1  one-cycle pulse: an 8-line band is buffered and ready to encode
h_mcu  in  MCU_W  MCUs per band; sampled on band accept
hdr_busy  in  1  header/footer emitter is active; band start is held off while high
elen_y, elen_cb, elen_cr  in  6 each  component encoder output lengths, monitored for collisions
ereq  out  3  per-component request: bit0 = Y, bit1 = Cb, bit2 = Cr
e_x_mcu_y, e_x_mcu_cb, e_x_mcu_cr  out  MCU_W each  MCU column index presented to each encoder
busy  out  1  band in progress or pending
band_done  out  1  one-cycle pulse when a band completes
err_overrun  out  1  sticky: line_go arrived while busy
err_collision  out  1  sticky: more than one elen_* nonzero in the same cycle

Behaviour:
- Reset (rst low, asynchronous): state IDLE; all outputs 0; pending flag cleared.
- FSM states: IDLE, PEND, REQ_Y, REQ_CB, REQ_CR, GUARD.
- IDLE + line_go:
  - hdr_busy low -> REQ_Y next cycle.
  - hdr_busy high -> PEND.
  - Either way, latch h_mcu into h_lat, zero all e_x_mcu_*, assert busy.
- PEND -> REQ_Y on the first cycle hdr_busy is low.
- Request slots:
  - REQ_Y holds ereq=3'b001 for SLOT_Y cycles, then REQ_CB.
  - REQ_CB holds 3'b010 for SLOT_C cycles, then REQ_CR.
  - REQ_CR holds 3'b100 for SLOT_C cycles, then GUARD.
  - ereq is registered, exactly one-hot during REQ_* states, 0 otherwise.
- GUARD: ereq=0 for GUARD cycles. Afterwards:
  - If MCU count + 1 < h_lat -> REQ_Y for the next MCU.
  - Else -> IDLE with band_done pulsed in the IDLE-entry cycle; busy drops in that same cycle.
- e_x_mcu_*: each counter increments by 1 in the cycle after its component's slot ends. It is stable for the whole slot.
- Slot cycle count, line_go to first ereq: 1 cycle when hdr_busy is low.
- Cycles per MCU: SLOT_Y + 2*SLOT_C + GUARD (19 at defaults).
- h_mcu == 0 on accept: no ereq; band_done pulses the next cycle.
- line_go while busy:
  - Ignored; set err_overrun.
  - The band in progress continues undisturbed.
- frame_start:
  - Highest priority. Any state -> IDLE next cycle.
  - ereq, e_x_mcu_* and busy are zeroed; no band_done.
  - err_overrun and err_collision are cleared.
  - A line_go in the same cycle is ignored.
- Collision monitor: runs in every state. Two or more of elen_y, elen_cb, elen_cr nonzero in a cycle sets err_collision from the next cycle onward.
- Counters are MCU_W bits wide. h_lat = 2^MCU_W - 1 is legal: the band ends when the count reaches h_lat, with no wrap.

Optional Feature:
MJPG_SCHED_STATS_EN:
- Defined: adds output band_cycles[15:0], which counts clk cycles from band accept through band_done.
  - Latched in the band_done cycle and held until the next band_done.
  - Saturates at 16'hFFFF.
  - Reset value 0; cleared on frame_start.
- Undefined: the port and logic are absent.

Test Plan:
- Reset, h_mcu=2, line_go at cycle 0 (hdr_busy=0):
  - ereq=001 in cycles 1-5, 010 in 6-8, 100 in 9-11, 0 in 12-19.
  - Second MCU in cycles 20-38; band_done in cycle 39.
  - e_x_mcu_y=1 from cycle 6; all counters 2 at the end.
- hdr_busy high for 10 cycles around line_go: busy=1 immediately; first ereq=001 in the cycle after hdr_busy falls.
- h_mcu=0, line_go: ereq stays 0; band_done pulses in the next cycle.
- line_go again at cycle 10 of an h_mcu=3 band: err_overrun=1; band still completes at cycle 58 with exactly 3 MCUs.
- elen_y=4 and elen_cr=7 in the same cycle: err_collision=1 the next cycle; frame_start clears it.
- frame_start in cycle 7 of a band: ereq=0 and busy=0 from cycle 8; no band_done; a fresh line_go restarts with e_x_mcu_*=0.
